// File: rtl/stream_fifo.sv
// stream_fifo
//   Synchronous FIFO between a push-only producer and a consumer that may stall.
//   Words go into a storage array and then into a single registered output stage,
//   which is offered to the consumer with a valid/ready handshake. Total capacity is
//   FIFO_SIZE words in storage plus one in the output register.
//
// Parameters
//   DATA_WIDTH   width of each word
//   FIFO_SIZE    storage depth, power of two, >= 2
//   ALMOST_FULL  almost_full threshold on level, 1..FIFO_SIZE
//
// Ports
//   clk                 clock, rising edge
//   reset               synchronous, active-high, highest priority
//   flush               synchronous clear of contents and flags (out_data kept)
//   in_data             word to push
//   in_data_available   push strobe, one word per cycle
//   receiver_ready      consumer accepts out_data this cycle
//   out_data_available  out_data holds a valid word
//   out_data            head word (registered)
//   full                storage holds FIFO_SIZE words
//   empty               storage holds no words (output register not counted)
//   almost_full         level >= ALMOST_FULL
//   level               words in storage
//   overflow            sticky: a push was dropped while full
//   high_water          max level since reset/flush (only with STREAM_FIFO_HIGH_WATER_EN)
//
// Build option
//   STREAM_FIFO_HIGH_WATER_EN  adds the high_water output and its register.

module stream_fifo #(
    parameter int  DATA_WIDTH  = 8,
    parameter int  FIFO_SIZE   = 32,
    parameter int  ALMOST_FULL = 28,
    localparam int LW          = $clog2(FIFO_SIZE) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_data_available,
    input  logic                  receiver_ready,
    output logic                  out_data_available,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [LW-1:0]         level,
    output logic                  overflow
`ifdef STREAM_FIFO_HIGH_WATER_EN
    ,
    output logic [LW-1:0]         high_water
`endif
);

    localparam int AW = LW - 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_SIZE];
    logic [LW-1:0]         wr_ptr;
    logic [LW-1:0]         rd_ptr;
    logic                  push;
    logic                  load;

    // Status is derived only from registered pointers, so no input reaches an output
    // combinationally. The extra MSB on each pointer separates full from empty.
    assign level       = wr_ptr - rd_ptr;
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[LW-1] != rd_ptr[LW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign almost_full = (level >= LW'(ALMOST_FULL));

    // full is taken from the current state: a pop this cycle does not make room for a push.
    assign push = in_data_available && !full;
    // Refill the output stage when it is empty or being consumed this cycle.
    assign load = (!out_data_available || receiver_ready) && !empty;

    // Storage array has no reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (!reset && !flush && push) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            overflow           <= 1'b0;
            out_data_available <= 1'b0;
            out_data           <= '0;
        end else if (flush) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            overflow           <= 1'b0;
            out_data_available <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + LW'(1);
            end else if (in_data_available) begin
                overflow <= 1'b1;
            end

            if (load) begin
                out_data           <= mem[rd_ptr[AW-1:0]];
                rd_ptr             <= rd_ptr + LW'(1);
                out_data_available <= 1'b1;
            end else if (out_data_available && receiver_ready) begin
                out_data_available <= 1'b0;
            end
        end
    end

`ifdef STREAM_FIFO_HIGH_WATER_EN
    // Tracks the registered level, so it trails level by one cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            high_water <= '0;
        end else if (level > high_water) begin
            high_water <= level;
        end
    end
`endif

endmodule

// File: tb/tb_stream_fifo.sv
module tb_stream_fifo;

    localparam int DW = 8;
    localparam int FS = 4;
    localparam int AF = 3;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_data_available = 1'b0;
    logic          receiver_ready = 1'b0;
    logic          out_data_available;
    logic [DW-1:0] out_data;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic [LW-1:0] level;
    logic          overflow;
`ifdef STREAM_FIFO_HIGH_WATER_EN
    logic [LW-1:0] high_water;
`endif

    stream_fifo #(.DATA_WIDTH(DW), .FIFO_SIZE(FS), .ALMOST_FULL(AF)) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .in_data(in_data),
        .in_data_available(in_data_available),
        .receiver_ready(receiver_ready),
        .out_data_available(out_data_available),
        .out_data(out_data),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .level(level),
        .overflow(overflow)
`ifdef STREAM_FIFO_HIGH_WATER_EN
        ,
        .high_water(high_water)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          fl;
        logic          av;
        logic          rr;
        logic [DW-1:0] d;
        logic          e_oda;
        logic [DW-1:0] e_od;
        logic          e_full;
        logic          e_empty;
        logic          e_af;
        logic [LW-1:0] e_lvl;
        logic          e_ov;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic rst, input logic fl, input logic av, input logic rr,
                       input logic [DW-1:0] d, input logic oda, input logic [DW-1:0] od,
                       input logic fu, input logic em, input logic af,
                       input logic [LW-1:0] lvl, input logic ov);
        vec_t v;
        v.rst = rst; v.fl = fl; v.av = av; v.rr = rr; v.d = d;
        v.e_oda = oda; v.e_od = od; v.e_full = fu; v.e_empty = em;
        v.e_af = af; v.e_lvl = lvl; v.e_ov = ov;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s step %0d: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    // Drive inputs away from the edge, then sample 1 ns after the rising edge.
    task automatic step(input logic rst, input logic fl, input logic av, input logic rr,
                        input logic [DW-1:0] d);
        @(negedge clk);
        reset = rst; flush = fl; in_data_available = av; receiver_ready = rr; in_data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int first_cyc;
        int last_cyc;
        bit full_seen;

        //   rst fl av rr  d       oda od    fu em af lvl ov
        add(1, 0, 0, 0, 8'h00,   0, 8'h00, 0, 1, 0, 0, 0);
        // single word, consumer ready: appears one cycle after the push edge
        add(0, 0, 1, 1, 8'h11,   0, 8'h00, 0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 8'h00,   1, 8'h11, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 8'h00,   0, 8'h11, 0, 1, 0, 0, 0);
        // consumer stalled: fill, almost_full, full, overflow
        add(0, 0, 1, 0, 8'h01,   0, 8'h11, 0, 0, 0, 1, 0);
        add(0, 0, 1, 0, 8'h02,   1, 8'h01, 0, 0, 0, 1, 0);
        add(0, 0, 1, 0, 8'h03,   1, 8'h01, 0, 0, 0, 2, 0);
        add(0, 0, 1, 0, 8'h04,   1, 8'h01, 0, 0, 1, 3, 0);
        add(0, 0, 1, 0, 8'h05,   1, 8'h01, 1, 0, 1, 4, 0);
        add(0, 0, 1, 0, 8'h06,   1, 8'h01, 1, 0, 1, 4, 1);
        // drain in order
        add(0, 0, 0, 1, 8'h00,   1, 8'h02, 0, 0, 1, 3, 1);
        add(0, 0, 0, 1, 8'h00,   1, 8'h03, 0, 0, 0, 2, 1);
        add(0, 0, 0, 1, 8'h00,   1, 8'h04, 0, 0, 0, 1, 1);
        add(0, 0, 0, 1, 8'h00,   1, 8'h05, 0, 1, 0, 0, 1);
        add(0, 0, 0, 1, 8'h00,   0, 8'h05, 0, 1, 0, 0, 1);
        // level 2, simultaneous push and pop
        add(0, 0, 1, 0, 8'hA1,   0, 8'h05, 0, 0, 0, 1, 1);
        add(0, 0, 1, 0, 8'hA2,   1, 8'hA1, 0, 0, 0, 1, 1);
        add(0, 0, 1, 0, 8'hA3,   1, 8'hA1, 0, 0, 0, 2, 1);
        add(0, 0, 1, 1, 8'hA4,   1, 8'hA2, 0, 0, 0, 2, 1);
        add(0, 0, 0, 0, 8'h00,   1, 8'hA2, 0, 0, 0, 2, 1);
        add(0, 0, 0, 1, 8'h00,   1, 8'hA3, 0, 0, 0, 1, 1);
        add(0, 0, 0, 1, 8'h00,   1, 8'hA4, 0, 1, 0, 0, 1);
        add(0, 0, 0, 1, 8'h00,   0, 8'hA4, 0, 1, 0, 0, 1);
        // fill to full with overflow, then flush (push/pop in flush cycle ignored)
        add(0, 0, 1, 0, 8'hB1,   0, 8'hA4, 0, 0, 0, 1, 1);
        add(0, 0, 1, 0, 8'hB2,   1, 8'hB1, 0, 0, 0, 1, 1);
        add(0, 0, 1, 0, 8'hB3,   1, 8'hB1, 0, 0, 0, 2, 1);
        add(0, 0, 1, 0, 8'hB4,   1, 8'hB1, 0, 0, 1, 3, 1);
        add(0, 0, 1, 0, 8'hB5,   1, 8'hB1, 1, 0, 1, 4, 1);
        add(0, 0, 1, 0, 8'hB6,   1, 8'hB1, 1, 0, 1, 4, 1);
        add(0, 1, 1, 1, 8'hB7,   0, 8'hB1, 0, 1, 0, 0, 0);
        // mid-stream reset clears out_data too
        add(0, 0, 1, 0, 8'hC1,   0, 8'hB1, 0, 0, 0, 1, 0);
        add(0, 0, 1, 0, 8'hC2,   1, 8'hC1, 0, 0, 0, 1, 0);
        add(1, 0, 1, 1, 8'hC3,   0, 8'h00, 0, 1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].fl, vecs[i].av, vecs[i].rr, vecs[i].d);
            chk("out_data_available", i, int'(out_data_available), int'(vecs[i].e_oda));
            chk("out_data", i, int'(out_data), int'(vecs[i].e_od));
            chk("full", i, int'(full), int'(vecs[i].e_full));
            chk("empty", i, int'(empty), int'(vecs[i].e_empty));
            chk("almost_full", i, int'(almost_full), int'(vecs[i].e_af));
            chk("level", i, int'(level), int'(vecs[i].e_lvl));
            chk("overflow", i, int'(overflow), int'(vecs[i].e_ov));
        end

        // 10 back-to-back words with the consumer always ready: wraps the pointers twice.
        n = 0; first_cyc = -1; last_cyc = -1; full_seen = 0;
        for (int c = 0; c < 20; c++) begin
            step(0, 0, (c < 10), 1, DW'(8'h20 + c));
            if (full) full_seen = 1;
            if (out_data_available) begin
                chk("stream_data", c, int'(out_data), 32'h20 + n);
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
                n++;
            end
        end
        chk("stream_count", 0, n, 10);
        chk("stream_back_to_back", 0, last_cyc - first_cyc, 9);
        chk("stream_first_latency", 0, first_cyc, 1);
        chk("stream_full_seen", 0, int'(full_seen), 0);

`ifdef STREAM_FIFO_HIGH_WATER_EN
        step(1, 0, 0, 0, 8'h00);
        step(0, 0, 1, 0, 8'hD1);
        step(0, 0, 1, 0, 8'hD2);
        step(0, 0, 1, 0, 8'hD3);
        step(0, 0, 1, 0, 8'hD4);
        chk("hw_level", 0, int'(level), 3);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 8'h00);
        chk("hw_drained", 0, int'(level), 0);
        chk("high_water", 0, int'(high_water), 3);
        step(0, 1, 0, 0, 8'h00);
        chk("high_water_flush", 0, int'(high_water), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
